video_fetch_sched: RTL and testbench
====================================

Name: video_fetch_sched

Overview:
Downstream consumer of the video mode decoder's required-bandwidth code (mode_bw). It turns the per-line fetch window into a paced stream of DRAM video-fetch requests: one request per 8/4/2/1 DRAM slots. It handshakes each request with the DRAM arbiter and tells the pixel pipe when a word has been fetched. It sits between the mode decoder/raster timing and the DRAM arbiter.

Parameters:
CNT_W, 8, width of the per-line fetched-word counter (fetch_cnt)
CREDIT_MAX, 3, maximum outstanding (due but unacknowledged) requests

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
slot_stb  in  1  one-cycle strobe marking each DRAM slot
line_start  in  1  one-cycle strobe at start of each scanline
fetch_en  in  1  fetch window active (level, from raster timing)
mode_bw  in  2  required bandwidth from the mode decoder: 00=1/8, 01=1/4, 10=1/2, 11=1
video_req  out  1  fetch request to arbiter
video_ack  in  1  arbiter grant; valid only while video_req=1
video_next  out  1  one-cycle pulse: a word was fetched
fetch_cnt  out  CNT_W  words fetched since last line_start
busy  out  1  state != IDLE
overrun  out  1  sticky: a due request was lost at full credit

Behaviour:
- Single clock domain; all outputs registered. Synchronous active-high reset.
- Reset values: state=IDLE, credit=0, phase=0, bw_l=00, fetch_cnt=0, video_next=0, overrun=0. Hence video_req=0, busy=0.
- bw_l latches mode_bw on line_start only. mode_bw changes mid-line are ignored until the next line_start.
- Period P = 8>>bw_l (8,4,2,1). phase is 3 bits and wraps modulo P.
- States:
  - IDLE: on line_start -> ARMED. fetch_en alone is ignored.
  - ARMED: on fetch_en=1 -> FETCH with phase=0. No credits are issued in the entry cycle.
  - FETCH: on each slot_stb, "due" if phase==0; then phase <= (phase+1) mod P. When fetch_en=0 -> DRAIN if credit!=0, else IDLE.
  - DRAIN: no new dues. Go to IDLE when credit reaches 0.
- line_start in any state (including mid-FETCH/DRAIN): clear credit and phase, clear fetch_cnt, re-latch bw_l, go to ARMED. A video_ack in the same cycle is discarded: no count, no video_next.
- Credit counter (0..CREDIT_MAX):
  - due and accepted ack in the same cycle: credit unchanged.
  - due only: credit+1. If credit==CREDIT_MAX, credit stays, the due is dropped, and overrun<=1.
  - accepted ack only: credit-1.
- video_req = (credit!=0), decoded from the credit register. It goes high the cycle after the due slot.
- Accepted ack = video_ack & video_req & !line_start. video_ack while video_req=0 is ignored.
- On accepted ack: fetch_cnt+1, saturating at 2^CNT_W-1. video_next pulses in the following cycle (latency 1).
- overrun is cleared only by rst.

Decomposition:
- Package video_fetch_pkg:
  - state encoding (IDLE, ARMED, FETCH, DRAIN)
  - BW_8, BW_4, BW_2, BW_1 constants matching the mode decoder's mode_bw codes
  - CREDIT_MAX default
- One natural sub-module, video_fetch_cadence: takes slot_stb, bw_l and a phase clear, and outputs the due strobe. It holds the phase counter and the P mask.

Test Plan:
- bw=00, line_start then fetch_en high for exactly 32 slot_stb, arbiter acks same cycle as req -> 4 requests, 4 video_next pulses, fetch_cnt=4, overrun=0, busy falls right after window.
- bw=11, window 10 slots, video_ack held 0 -> credit saturates at 3 after 3 slots, video_req stays 1, overrun=1. Then fetch_en low, 3 acks -> DRAIN to IDLE, fetch_cnt=3.
- bw=10, ack arrives exactly on a due slot with credit=1 -> credit stays 1, video_req stays 1, fetch_cnt+1.
- mode_bw changed 01->11 mid-line -> pacing stays 1/4 until next line_start, then 1/1.
- line_start during FETCH with credit=2 and simultaneous video_ack -> credit=0, fetch_cnt=0, no video_next, state ARMED.
- rst asserted mid-DRAIN with overrun=1 -> next cycle: all outputs at reset values, video_req=0.

Source files
------------

// File: rtl/video_fetch_pkg.sv
// Shared encodings for the video fetch scheduler: FSM states, bandwidth codes
// and the phase-mask helper used by the cadence counter.
package video_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Codes as produced by the mode decoder's mode_bw output.
  localparam logic [1:0] BW_8 = 2'b00;
  localparam logic [1:0] BW_4 = 2'b01;
  localparam logic [1:0] BW_2 = 2'b10;
  localparam logic [1:0] BW_1 = 2'b11;

  localparam int CREDIT_MAX_DEF = 3;

  // Period is 8>>bw, so the wrap mask is period-1.
  function automatic logic [2:0] phase_mask(input logic [1:0] bw);
    logic [2:0] m;
    case (bw)
      BW_8:    m = 3'd7;
      BW_4:    m = 3'd3;
      BW_2:    m = 3'd1;
      default: m = 3'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/video_fetch_cadence.sv
// Slot cadence: counts DRAM slots modulo the latched period and flags the
// slot on which a fetch becomes due.
module video_fetch_cadence
  import video_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_run,
  input  logic       i_slot_stb,
  input  logic [1:0] i_bw,
  output logic       o_due
);

  logic [2:0] r_phase;
  logic [2:0] w_mask;

  assign w_mask = phase_mask(i_bw);
  assign o_due  = i_run & i_slot_stb & (r_phase == 3'd0);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_phase <= 3'd0;
    end else if (i_run && i_slot_stb) begin
      r_phase <= (r_phase + 3'd1) & w_mask;
    end
  end

endmodule

// File: rtl/video_fetch_sched.sv
// Paces video fetch requests over the per-line fetch window and tracks
// outstanding requests as credits against the DRAM arbiter.
module video_fetch_sched
  import video_fetch_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slot_stb,
  input  logic             line_start,
  input  logic             fetch_en,
  input  logic [1:0]       mode_bw,
  output logic             video_req,
  input  logic             video_ack,
  output logic             video_next,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  localparam int              CR_W   = $clog2(CREDIT_MAX + 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDIT_MAX);
  localparam logic [CR_W-1:0] CR_ONE = CR_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CR_W-1:0]  r_credit, w_credit_nxt;
  logic [1:0]       r_bw_l;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             r_next;
  logic             r_overrun;
  logic             w_req, w_ack_ok, w_due, w_run, w_clr, w_drop;

  // Handshake: video_req stays high while any credit is outstanding; a word
  // transfers in each cycle where video_ack and video_req are both high,
  // except a line_start cycle, which discards the ack.
  assign w_req    = (r_credit != '0);
  assign w_ack_ok = video_ack & w_req & ~line_start;
  assign w_run    = (r_state == ST_FETCH) & fetch_en & ~line_start;
  assign w_clr    = line_start | (r_state == ST_ARMED);

  video_fetch_cadence u_cadence (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_run      (w_run),
    .i_slot_stb (slot_stb),
    .i_bw       (r_bw_l),
    .o_due      (w_due)
  );

  always_comb begin
    w_credit_nxt = r_credit;
    w_drop       = 1'b0;
    if (line_start) begin
      w_credit_nxt = '0;
    end else if (w_due && !w_ack_ok) begin
      if (r_credit == CR_MAX) w_drop = 1'b1;
      else                    w_credit_nxt = r_credit + CR_ONE;
    end else if (w_ack_ok && !w_due) begin
      w_credit_nxt = r_credit - CR_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (line_start) begin
      w_state_nxt = ST_ARMED;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_ARMED: if (fetch_en) w_state_nxt = ST_FETCH;
        ST_FETCH: if (!fetch_en) w_state_nxt = (r_credit != '0) ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: if (w_credit_nxt == '0) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_credit    <= '0;
      r_bw_l      <= BW_8;
      r_fetch_cnt <= '0;
      r_next      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_next   <= w_ack_ok;
      if (line_start) r_bw_l <= mode_bw;
      if (line_start) begin
        r_fetch_cnt <= '0;
      end else if (w_ack_ok && (r_fetch_cnt != '1)) begin
        r_fetch_cnt <= r_fetch_cnt + 1'b1;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign video_req  = w_req;
  assign video_next = r_next;
  assign fetch_cnt  = r_fetch_cnt;
  assign busy       = (r_state != ST_IDLE);
  assign overrun    = r_overrun;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_video_fetch_sched.sv
// Bench for video_fetch_sched: directed vector table plus pacing loops, with a
// queue scoreboard pairing each accepted ack with its video_next pulse.
module tb_video_fetch_sched;
  import video_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slot_stb = 1'b0;
  logic       line_start = 1'b0;
  logic       fetch_en = 1'b0;
  logic [1:0] mode_bw = 2'b00;
  logic       video_ack = 1'b0;
  logic       video_req;
  logic       video_next;
  logic [7:0] fetch_cnt;
  logic       busy;
  logic       overrun;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  video_fetch_sched #(.CNT_W(8), .CREDIT_MAX(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .slot_stb   (slot_stb),
    .line_start (line_start),
    .fetch_en   (fetch_en),
    .mode_bw    (mode_bw),
    .video_req  (video_req),
    .video_ack  (video_ack),
    .video_next (video_next),
    .fetch_cnt  (fetch_cnt),
    .busy       (busy),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  typedef struct {
    logic       rst;
    logic       ls;
    logic       fe;
    logic       stb;
    logic [1:0] bw;
    logic       ack;
    logic       e_req;
    logic       e_nxt;
    logic [7:0] e_cnt;
    logic       e_busy;
    logic       e_ovr;
    logic [1:0] e_st;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];
  logic [7:0] sb_cnt = 8'd0;
  logic       exp_req_now = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  localparam int I = 0;
  localparam int A = 1;
  localparam int F = 2;
  localparam int D = 3;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int r, input int l, input int f, input int s,
                              input int b, input int a, input int req, input int nxt,
                              input int cnt, input int bsy, input int ovr, input int st);
    vec_t x;
    x.rst = (r != 0);  x.ls = (l != 0);  x.fe = (f != 0);  x.stb = (s != 0);
    x.bw = 2'(b);      x.ack = (a != 0);
    x.e_req = (req != 0); x.e_nxt = (nxt != 0); x.e_cnt = 8'(cnt);
    x.e_busy = (bsy != 0); x.e_ovr = (ovr != 0); x.e_st = 2'(st);
    tbl.push_back(x);
  endfunction

  // Drive one cycle, update the scoreboard model, then sample after the edge.
  task automatic step(input logic r, input logic l, input logic f, input logic s,
                      input logic [1:0] b, input logic a);
    logic       acc;
    logic [7:0] e;
    @(negedge clk);
    rst = r; line_start = l; fetch_en = f; slot_stb = s; mode_bw = b; video_ack = a;
    acc = a & exp_req_now & ~l & ~r;
    if (r || l) sb_cnt = 8'd0;
    else if (acc && sb_cnt != 8'hFF) sb_cnt = sb_cnt + 8'd1;
    if (acc) exp_q.push_back(sb_cnt);
    @(posedge clk);
    #1;
    if (video_next) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_next: got unexpected video_next, expected none");
      end else begin
        e = exp_q.pop_front();
        chk("sb_cnt", int'(fetch_cnt), int'(e));
      end
    end
  endtask

  task automatic expect_all(input string tag, input int req, input int nxt, input int cnt,
                            input int bsy, input int ovr, input int st);
    chk({tag, ".req"},   int'(video_req),  req);
    chk({tag, ".next"},  int'(video_next), nxt);
    chk({tag, ".cnt"},   int'(fetch_cnt),  cnt);
    chk({tag, ".busy"},  int'(busy),       bsy);
    chk({tag, ".ovr"},   int'(overrun),    ovr);
    chk({tag, ".state"}, int'(dbg_state),  st);
    exp_req_now = (req != 0);
  endtask

  initial begin
    // Reset, then bw=11 saturation with ack held low, then drain by 3 acks.
    add(1,0,0,0,0,0, 0,0,0,0,0,I);
    add(0,1,0,0,3,0, 0,0,0,1,0,A);
    add(0,0,1,0,3,0, 0,0,0,1,0,F);
    for (int k = 0; k < 3; k++) add(0,0,1,1,3,0, 1,0,0,1,0,F);
    for (int k = 0; k < 7; k++) add(0,0,1,1,3,0, 1,0,0,1,1,F);
    add(0,0,0,0,3,0, 1,0,0,1,1,D);
    add(0,0,0,0,3,1, 1,1,1,1,1,D);
    add(0,0,0,0,3,1, 1,1,2,1,1,D);
    add(0,0,0,0,3,1, 0,1,3,0,1,I);
    add(0,0,0,0,3,0, 0,0,3,0,1,I);
    // Reset asserted mid-DRAIN with overrun set and an ack pending.
    add(0,1,0,0,3,0, 0,0,0,1,1,A);
    add(0,0,1,0,3,0, 0,0,0,1,1,F);
    add(0,0,1,1,3,0, 1,0,0,1,1,F);
    add(0,0,0,0,3,0, 1,0,0,1,1,D);
    add(1,0,0,0,3,1, 0,0,0,0,0,I);
    add(0,0,0,0,3,0, 0,0,0,0,0,I);
    // line_start mid-FETCH at credit 2 with a simultaneous ack.
    add(0,1,0,0,3,0, 0,0,0,1,0,A);
    add(0,0,1,0,3,0, 0,0,0,1,0,F);
    add(0,0,1,1,3,0, 1,0,0,1,0,F);
    add(0,0,1,1,3,0, 1,0,0,1,0,F);
    add(0,0,1,1,3,1, 1,1,1,1,0,F);
    add(0,1,1,0,3,1, 0,0,0,1,0,A);
    add(0,0,1,0,3,0, 0,0,0,1,0,F);
    add(0,0,0,0,3,0, 0,0,0,0,0,I);
    // bw=10: ack lands on a due slot at credit 1; stray ack while idle.
    add(1,0,0,0,2,0, 0,0,0,0,0,I);
    add(0,1,0,0,2,0, 0,0,0,1,0,A);
    add(0,0,1,0,2,0, 0,0,0,1,0,F);
    add(0,0,1,1,2,0, 1,0,0,1,0,F);
    add(0,0,1,1,2,0, 1,0,0,1,0,F);
    add(0,0,1,1,2,1, 1,1,1,1,0,F);
    add(0,0,1,0,2,1, 0,1,2,1,0,F);
    add(0,0,0,0,2,0, 0,0,2,0,0,I);
    add(0,0,0,0,2,1, 0,0,2,0,0,I);

    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].rst, tbl[n].ls, tbl[n].fe, tbl[n].stb, tbl[n].bw, tbl[n].ack);
      expect_all($sformatf("v%0d", n), int'(tbl[n].e_req), int'(tbl[n].e_nxt),
                 int'(tbl[n].e_cnt), int'(tbl[n].e_busy), int'(tbl[n].e_ovr),
                 int'(tbl[n].e_st));
    end

    // bw=00 over a 32-slot window, arbiter acks whenever req is up.
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_all("b8.ls", 0,0,0,1,0,A);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    expect_all("b8.en", 0,0,0,1,0,F);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, exp_req_now);
      expect_all($sformatf("b8.s%0d", i), int'(i % 8 == 0), int'(i % 8 == 1),
                 int'(i >= 1) + int'(i >= 9) + int'(i >= 17) + int'(i >= 25), 1, 0, F);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_all("b8.end", 0,0,4,0,0,I);

    // bw=01 line with mode_bw switched to 11 mid-line: pacing stays 1/4.
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    expect_all("mc.ls", 0,0,0,1,0,A);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
    expect_all("mc.en", 0,0,0,1,0,F);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, (k == 0) ? 2'd1 : 2'd3, exp_req_now);
      expect_all($sformatf("mc.s%0d", k), int'(k % 4 == 0), int'(k % 4 == 1),
                 (k + 3) / 4, 1, 0, F);
    end
    // Next line picks up 1/1; long window also drives fetch_cnt to saturation.
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    expect_all("mc.ls2", 0,0,0,1,0,A);
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0);
    expect_all("mc.en2", 0,0,0,1,0,F);
    for (int k = 0; k < 260; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, exp_req_now);
      expect_all($sformatf("b1.s%0d", k), 1, int'(k >= 1), (k > 255) ? 255 : k, 1, 0, F);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, exp_req_now);
    expect_all("b1.off", 0,1,255,1,0,D);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
    expect_all("b1.end", 0,0,255,0,0,I);

    chk("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
